// File: rtl/perf_counter_bank.sv
// Bank of NUM_EVT event counters plus a cycle counter that freeze on halt, with a one-cycle-latency read port.
// Optional build macro PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module perf_counter_bank #(
  parameter int NUM_EVT = 5,
  parameter int CNT_W   = 32,
  parameter int IDX_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_err,
  output logic [NUM_EVT:0]   ovf,
  output logic               halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt [NUM_EVT+1];
  logic [NUM_EVT:0]   inc;
  logic               count_en;
  logic               idx_ok;
  logic [CNT_W-1:0]   rd_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // clr wins over halt and over counting in the same cycle.
  always_comb begin
    state_nxt = state;
    count_en  = 1'b0;
    if (clr) begin
      state_nxt = RUN;
    end else if (state == RUN) begin
      count_en = en;
      if (halt) state_nxt = HALTED;
    end
  end

  assign halted = (state == HALTED);

  // Top slot is the cycle counter, which increments on every enabled cycle.
  assign inc = {1'b1, evt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NUM_EVT; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (clr) begin
      for (int i = 0; i <= NUM_EVT; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (count_en) begin
      for (int i = 0; i <= NUM_EVT; i++) begin
        if (inc[i]) begin
`ifdef PERF_SATURATE_EN
          if (&cnt[i]) ovf[i] <= 1'b1;
          else         cnt[i] <= cnt[i] + CNT_W'(1);
`else
          cnt[i] <= cnt[i] + CNT_W'(1);
          if (&cnt[i]) ovf[i] <= 1'b1;
`endif
        end
      end
    end
  end

  assign idx_ok = (rd_idx <= IDX_W'(NUM_EVT));

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_idx == IDX_W'(i)) rd_mux = cnt[i];
    end
  end

  // Read samples pre-update counter values; rd_data holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req && !idx_ok;
      if (rd_req) rd_data <= idx_ok ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (CNT_W=8): reference model plus read scoreboard queue.
module tb_perf_counter_bank;

  localparam int NE = 5;
  localparam int CW = 8;
  localparam int IW = 3;
  localparam logic [CW-1:0] MAXV = '1;
`ifdef PERF_SATURATE_EN
  localparam logic [CW-1:0] EXP_OVF = 8'd255;
`else
  localparam logic [CW-1:0] EXP_OVF = 8'd4;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic          clr;
  logic [NE-1:0] evt;
  logic          halt;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic          rd_err;
  logic [NE:0]   ovf;
  logic          halted;

  typedef struct packed {
    logic          err;
    logic [CW-1:0] data;
  } rd_exp_t;

  rd_exp_t       exp_q[$];
  logic [CW-1:0] m_cnt [NE+1];
  logic [NE:0]   m_ovf;
  logic          m_halted;
  logic [CW-1:0] m_last;
  int            n_assert;
  int            n_fail;

  perf_counter_bank #(.NUM_EVT(NE), .CNT_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .halt(halt),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .ovf(ovf), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= NE; i++) m_cnt[i] = '0;
    m_ovf    = '0;
    m_halted = 1'b0;
    m_last   = '0;
    exp_q.delete();
  endtask

  // Behaviour at one rising edge: clr clears, HALTED freezes, halt enters HALTED even with en low.
  task automatic model_step(input logic s_en, input logic s_clr, input logic [NE-1:0] s_evt, input logic s_halt);
    logic [NE:0] incv;
    incv = {1'b1, s_evt};
    if (s_clr) begin
      for (int i = 0; i <= NE; i++) m_cnt[i] = '0;
      m_ovf    = '0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (s_en) begin
        for (int i = 0; i <= NE; i++) begin
          if (incv[i]) begin
            if (m_cnt[i] == MAXV) begin
              m_ovf[i] = 1'b1;
`ifndef PERF_SATURATE_EN
              m_cnt[i] = '0;
`endif
            end else begin
              m_cnt[i] = m_cnt[i] + CW'(1);
            end
          end
        end
      end
      if (s_halt) m_halted = 1'b1;
    end
  endtask

  task automatic checkOutput();
    rd_exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_valid_hi", 64'(rd_valid), 64'(1));
      check("rd_data", 64'(rd_data), 64'(e.data));
      check("rd_err", 64'(rd_err), 64'(e.err));
      m_last = e.data;
    end else begin
      check("rd_valid_lo", 64'(rd_valid), 64'(0));
      check("rd_err_idle", 64'(rd_err), 64'(0));
      check("rd_data_hold", 64'(rd_data), 64'(m_last));
    end
    check("halted", 64'(halted), 64'(m_halted));
    check("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  // Drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic applyStimulus(input logic s_en, input logic s_clr, input logic [NE-1:0] s_evt,
                               input logic s_halt, input logic s_rd, input logic [IW-1:0] s_idx);
    rd_exp_t e;
    int      idx;
    en     = s_en;
    clr    = s_clr;
    evt    = s_evt;
    halt   = s_halt;
    rd_req = s_rd;
    rd_idx = s_idx;
    @(posedge clk);
    if (s_rd) begin
      idx = int'(s_idx);
      e.err  = (idx > NE);
      e.data = '0;
      if (idx <= NE) e.data = m_cnt[idx];
      exp_q.push_back(e);
    end
    model_step(s_en, s_clr, s_evt, s_halt);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int idxs [7];
    int exps [7];
    n_assert = 0;
    n_fail   = 0;
    idxs = '{0, 1, 2, 3, 5, 6, 7};
    exps = '{5, 4, 5, 4, 5, 0, 0};
    rst = 1'b1; en = 1'b0; clr = 1'b0; evt = '0; halt = 1'b0; rd_req = 1'b0; rd_idx = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_rd_valid", 64'(rd_valid), 64'(0));
    check("reset_rd_data", 64'(rd_data), 64'(0));
    check("reset_rd_err", 64'(rd_err), 64'(0));
    check("reset_halted", 64'(halted), 64'(0));
    check("reset_ovf", 64'(ovf), 64'(0));
    rst = 1'b0;
    applyStimulus(0, 0, '0, 0, 0, 0);

    $display("[TB] count ch0 ten times then halt");
    repeat (10) applyStimulus(1, 0, 5'b00001, 0, 0, 0);
    applyStimulus(1, 0, 5'b00000, 1, 0, 0);
    check("halted_after_halt", 64'(halted), 64'(1));
    applyStimulus(1, 0, 5'b11111, 0, 1, 3'd0);
    check("t1_idx0", 64'(rd_data), 64'(10));
    applyStimulus(1, 0, 5'b11111, 1, 1, 3'd5);
    check("t1_cycle", 64'(rd_data), 64'(11));
    applyStimulus(1, 0, 5'b11111, 0, 1, 3'd0);
    check("t1_frozen", 64'(rd_data), 64'(10));

    $display("[TB] clr with events and a same-cycle read");
    applyStimulus(1, 1, 5'b11111, 1, 1, 3'd5);
    check("clr_preclear_read", 64'(rd_data), 64'(11));
    check("clr_halted", 64'(halted), 64'(0));
    check("clr_ovf", 64'(ovf), 64'(0));
    applyStimulus(1, 0, 5'b11111, 0, 1, 3'd0);
    check("clr_zero", 64'(rd_data), 64'(0));
    applyStimulus(0, 0, 5'b00000, 0, 1, 3'd4);
    check("clr_then_one", 64'(rd_data), 64'(1));

    $display("[TB] halt together with events, then back-to-back reads");
    repeat (3) applyStimulus(1, 0, 5'b11111, 0, 0, 0);
    applyStimulus(1, 0, 5'b10101, 1, 0, 0);
    check("halt_evt_halted", 64'(halted), 64'(1));
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, 0, 5'(k + 1), 1, 1, IW'(idxs[k]));
      check("b2b_data", 64'(rd_data), 64'(exps[k]));
      check("b2b_err", 64'(rd_err), 64'(k >= 5));
    end
    applyStimulus(0, 0, '0, 0, 0, 0);

    $display("[TB] halt with en low counts nothing");
    applyStimulus(0, 1, '0, 0, 0, 0);
    applyStimulus(1, 0, 5'b11111, 0, 0, 0);
    applyStimulus(0, 0, 5'b11111, 1, 0, 0);
    applyStimulus(1, 0, 5'b11111, 0, 1, 3'd5);
    check("halt_en0_cycle", 64'(rd_data), 64'(1));
    check("halt_en0_halted", 64'(halted), 64'(1));

    $display("[TB] 260 events on ch1");
    applyStimulus(0, 1, '0, 0, 0, 0);
    repeat (260) applyStimulus(1, 0, 5'b00010, 0, 0, 0);
    applyStimulus(0, 0, '0, 0, 1, 3'd1);
    check("ovf_ch1_value", 64'(rd_data), 64'(EXP_OVF));
    check("ovf_ch1_flag", 64'(ovf[1]), 64'(1));
    check("ovf_ch0_flag", 64'(ovf[0]), 64'(0));
    applyStimulus(0, 0, '0, 0, 1, 3'd5);
    check("ovf_cycle_value", 64'(rd_data), 64'(EXP_OVF));
    applyStimulus(1, 0, 5'b00010, 0, 0, 0);
    check("ovf_sticky", 64'(ovf[1]), 64'(1));

    $display("[TB] randomised traffic");
    applyStimulus(0, 1, '0, 0, 0, 0);
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                    NE'($urandom_range(0, 31)), 1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)));
    end

    $display("[TB] asynchronous reset with a read in flight");
    applyStimulus(1, 0, 5'b11111, 1, 0, 0);
    applyStimulus(1, 0, 5'b11111, 0, 1, 3'd5);
    check("pre_reset_valid", 64'(rd_valid), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rd_valid", 64'(rd_valid), 64'(0));
    check("async_rd_data", 64'(rd_data), 64'(0));
    check("async_halted", 64'(halted), 64'(0));
    check("async_ovf", 64'(ovf), 64'(0));
    model_reset();
    en = 1'b0; rd_req = 1'b0; evt = '0; halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= NE; k++) begin
      applyStimulus(0, 0, '0, 0, 1, IW'(k));
      check("post_reset_zero", 64'(rd_data), 64'(0));
    end
    applyStimulus(1, 0, 5'b00100, 0, 0, 0);
    applyStimulus(0, 0, '0, 0, 1, 3'd2);
    check("post_reset_run", 64'(rd_data), 64'(1));
    applyStimulus(0, 0, '0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Synthesizable, parametrised bank of event counters that replaces bench-only counting of retired instructions, I/D-cache requests and hits, and cycles.
- Sits beside the processor top; each event input is a 1-cycle strobe from pipeline/cache logic.
- Counts until halt, then freezes; counts are read through a pipelined single-cycle-latency read port, so software or the bench can fetch final statistics after halt.

Parameters:
- NUM_EVT, 5, number of event channels (e.g. retire, icache_req, icache_hit, dcache_req, dcache_hit).
- CNT_W, 32, width of every counter, including the cycle counter; legal range 8..64.
- IDX_W, 3, read-index width; must satisfy 2**IDX_W >= NUM_EVT+1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; while low, counters hold.
- clr  in  1  synchronous clear of all counters, overflow flags and halted state.
- evt  in  NUM_EVT  per-channel event strobes, one count per cycle per asserted bit.
- halt  in  1  processor halt strobe (WB stage).
- rd_req  in  1  read request.
- rd_idx  in  IDX_W  0..NUM_EVT-1 selects an event counter; NUM_EVT selects the cycle counter.
- rd_valid  out  1  read data valid.
- rd_data  out  CNT_W  read data.
- rd_err  out  1  index out of range.
- ovf  out  NUM_EVT+1  sticky overflow flags; bit NUM_EVT is for the cycle counter.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (async): state RUN; all counters 0; ovf 0; rd_valid 0; rd_data 0; rd_err 0; halted 0.
- Two states, RUN and HALTED.
  - RUN: each cycle with en=1, cycle counter +1 and each counter i +evt[i].
  - RUN & halt & en: the halt cycle itself is counted (cycle +1, evt bits counted), then the state moves to HALTED.
  - halt with en=0: the state still moves to HALTED, and nothing is counted.
  - HALTED: all counters frozen; further evt/halt ignored.
  - clr in any state: next state RUN, all counters 0, ovf 0, halted 0. clr dominates the same-cycle evt/halt, so the counter becomes 0, not 1, and the state stays RUN.
- Overflow: increment from all-ones wraps to 0 and sets ovf[i]. The flag stays set until clr or rst.
- Read port:
  - rd_req sampled at edge N; rd_valid=1 and rd_data/rd_err are valid for exactly cycle N+1.
  - Back-to-back requests are allowed, one per cycle, with no stall.
  - rd_data returns the counter value before the update in cycle N.
  - Out-of-range idx (> NUM_EVT): rd_data=0, rd_err=1.
  - rd_valid=0 forces rd_err=0; rd_data holds its last value.
- A read in the same cycle as clr returns the pre-clear value.
- A reset mid-read drops the pending response; rd_valid=0 immediately.

Optional Feature:
- Macro PERF_SATURATE_EN.
- Defined: counters saturate at all-ones instead of wrapping. ovf[i] is set on the first attempted increment past all-ones, and the counter holds at all-ones until clr.
- Undefined: wrap-around behaviour as above.
- Read port and state machine are identical in both builds.

Test Plan:
- Reset, en=1, drive evt=5'b00001 for 10 cycles, then halt for 1 cycle -> after halt, read idx0 returns 10 and idx5 (cycle) returns 11; halted=1; further evt leaves values unchanged.
- evt=5'b10101 asserted together with halt in the same cycle -> each of ch0/2/4 gets that cycle counted; state HALTED next cycle.
- CNT_W=8, 260 events on ch1:
  - wrap build: read=4, ovf[1]=1.
  - PERF_SATURATE_EN build: read=255, ovf[1]=1.
- clr asserted in the same cycle as evt=5'b11111 -> all counters read 0, ovf=0, halted=0; the next cycle's events count from 0.
- rd_req on idx 0,1,2,5,6 on consecutive cycles -> rd_valid high for 5 consecutive cycles with the matching data; idx6 gives rd_data=0, rd_err=1.
- Assert rst asynchronously mid-count, with a read pending -> rd_valid drops without waiting for a clock, all counters 0, state RUN.
